// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: syncs source edges, latches payloads, grants one source to the CPU.
// Optional ack-wait timeout is enabled by defining IRQ_TIMEOUT_EN.
module irq_arbiter #(
  parameter int unsigned NSRC       = 4,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        srcEv,
  input  logic [NSRC*DATA_W-1:0] srcData,
  input  logic [NSRC-1:0]        srcMask,
  input  logic                   intEn,
  input  logic [ADDR_W-1:0]      vecBase,
  input  logic                   turnOffIRQ,
  output logic                   irq,
  output logic [DATA_W-1:0]      intData,
  output logic [ADDR_W-1:0]      intAddr,
  output logic [2:0]             activeSrc,
  output logic [NSRC-1:0]        pending,
  output logic [NSRC-1:0]        overflow,
  output logic                   err
);

  typedef enum logic [1:0] {StIdle, StGrant, StWaitAck, StRelease} state_e;

  state_e state_q, state_d;

  logic [NSRC-1:0]   ev_s1_q, ev_s2_q, ev_s3_q, ev_edge, ev_take;
  logic              ack_s1_q, ack_s_q;
  logic [DATA_W-1:0] payload_q [NSRC];
  logic [NSRC-1:0]   pending_q, pending_d, overflow_q, overflow_d, req, clr_vec;
  logic [2:0]        grant_q, grant_d, pick, active_q, active_d;
  logic              irq_q, irq_d, clr_grant;
  logic [DATA_W-1:0] data_q, data_d, sel_payload;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign ev_edge = ev_s2_q & ~ev_s3_q;
  assign ev_take = ev_edge & srcMask;
  assign req     = pending_q & srcMask;
  assign clr_vec = clr_grant ? (NSRC'(1) << grant_q) : '0;

`ifdef IRQ_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ev_s1_q  <= '0;
      ev_s2_q  <= '0;
      ev_s3_q  <= '0;
      ack_s1_q <= 1'b0;
      ack_s_q  <= 1'b0;
    end else begin
      ev_s1_q  <= srcEv;
      ev_s2_q  <= ev_s1_q;
      ev_s3_q  <= ev_s2_q;
      ack_s1_q <= turnOffIRQ;
      ack_s_q  <= ack_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NSRC; i++) payload_q[i] <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (ev_take[i]) payload_q[i] <= srcData[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lowest enabled pending index wins.
  always_comb begin
    pick = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) pick = 3'(i);
    end
  end

  always_comb begin
    sel_payload = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant_q == 3'(i)) sel_payload = payload_q[i];
    end
  end

  // A fresh edge on the source being granted keeps it pending without flagging overflow.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    for (int i = 0; i < NSRC; i++) begin
      if (ev_take[i]) begin
        pending_d[i] = 1'b1;
        if (pending_q[i] && !clr_vec[i]) overflow_d[i] = 1'b1;
      end else if (clr_vec[i]) begin
        pending_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    irq_d     = irq_q;
    data_d    = data_q;
    addr_d    = addr_q;
    active_d  = active_q;
    clr_grant = 1'b0;
`ifdef IRQ_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (intEn && (|req)) begin
          grant_d = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        data_d    = sel_payload;
        addr_d    = vecBase + ADDR_W'(grant_q) * ADDR_W'(VEC_STRIDE);
        active_d  = grant_q;
        irq_d     = 1'b1;
        clr_grant = 1'b1;
        state_d   = StWaitAck;
`ifdef IRQ_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      StWaitAck: begin
        if (ack_s_q) begin
          irq_d   = 1'b0;
          state_d = StRelease;
        end
`ifdef IRQ_TIMEOUT_EN
        else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          irq_d   = 1'b0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      // Hold here until ack drops so one long ack retires only one request.
      StRelease: begin
        if (!ack_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      irq_q      <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      active_q   <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      irq_q      <= irq_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      active_q   <= active_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef IRQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign irq       = irq_q;
  assign intData   = data_q;
  assign intAddr   = addr_q;
  assign activeSrc = active_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule
